// File: rtl/actor_motion_fsm.sv
// Per-actor sprite motion controller: GROUND/AIR/CLIMB state machine with
// fixed-point physics, screen clamping, head-bump, fall-out and respawn.
module actor_motion_fsm #(
  parameter int COORD_W     = 11,
  parameter int FRAC_BITS   = 6,
  parameter int INIT_X      = 280,
  parameter int INIT_Y      = 185,
  parameter int X_MIN       = -9,
  parameter int X_MAX       = 570,
  parameter int Y_FLOOR     = 479,
  parameter int WALK_SPEED  = 200,
  parameter int CLIMB_SPEED = 100,
  parameter int JUMP_SPEED  = 300,
  parameter int GRAVITY     = 10,
  parameter int MAX_FALL    = 230
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame_i,
  input  logic               leftPressed_i,
  input  logic               rightPressed_i,
  input  logic               upPressed_i,
  input  logic               downPressed_i,
  input  logic               collision_i,
  input  logic               onLedge_i,
  input  logic               onRope_i,
  input  logic [3:0]         hitEdgeCode_i,
  input  logic               respawn_i,
  output logic [COORD_W-1:0] topLeftX_o,
  output logic [COORD_W-1:0] topLeftY_o,
  output logic [1:0]         motionState_o,
  output logic               facingLeft_o,
  output logic               fellOut_o
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    AIR    = 2'd1,
    CLIMB  = 2'd2
  } stateT;

  localparam int SCALE   = 1 << FRAC_BITS;
  localparam int INIT_XF = INIT_X * SCALE;
  localparam int INIT_YF = INIT_Y * SCALE;
  localparam int X_MINF  = X_MIN * SCALE;
  localparam int X_MAXF  = X_MAX * SCALE;

  stateT              state_q, state_d;
  logic signed [31:0] xPos_q, xPos_d;
  logic signed [31:0] yPos_q, yPos_d;
  logic signed [31:0] xSpeed_q, xSpeed_d;
  logic signed [31:0] ySpeed_q, ySpeed_d;
  logic               facingLeft_q, facingLeft_d;
  logic               fellOut_q, fellOut_d;

  logic               leftOnly, rightOnly, footing;
  logic signed [31:0] xPix, walkXs, nXs, nYs, fallYs;
  logic signed [31:0] sumX, newX, newY, newYPix;
  stateT              nextState;

  assign xPix = xPos_q >>> FRAC_BITS;

  always_comb begin
    leftOnly  = leftPressed_i & ~rightPressed_i;
    rightOnly = rightPressed_i & ~leftPressed_i;
    footing   = onLedge_i & collision_i;
    walkXs    = rightOnly ? WALK_SPEED : (leftOnly ? -WALK_SPEED : 0);
    nextState = state_q;
    nXs       = walkXs;
    nYs       = ySpeed_q;
    fallYs    = ySpeed_q + GRAVITY;

    case (state_q)
      GROUND: begin
        if (upPressed_i && onRope_i) begin
          nextState = CLIMB;
          nYs       = -CLIMB_SPEED;
        end else if (upPressed_i) begin
          nextState = AIR;
          nYs       = -JUMP_SPEED;
        end else if (!footing && !onRope_i) begin
          nextState = AIR;
          nYs       = 0;
        end else begin
          nYs = 0;
        end
      end
      CLIMB: begin
        if (!onRope_i) begin
          nextState = AIR;
          nYs       = 0;
        end else if (leftOnly || rightOnly) begin
          nextState = AIR;
          nYs       = 0;
        end else begin
          nXs = 0;
          if (upPressed_i && !downPressed_i)
            nYs = -CLIMB_SPEED;
          else if (downPressed_i && !upPressed_i)
            nYs = CLIMB_SPEED;
          else
            nYs = 0;
        end
      end
      AIR: begin
        if (onRope_i) begin
          nextState = CLIMB;
          nYs       = 0;
        end else if (footing && ySpeed_q >= 0) begin
          nextState = GROUND;
          nYs       = 0;
        end else if (collision_i && hitEdgeCode_i[2] && ySpeed_q < 0) begin
          nYs = 0;
        end else begin
          nYs = (fallYs > MAX_FALL) ? MAX_FALL : fallYs;
        end
      end
      default: begin
        nextState = GROUND;
        nYs       = 0;
      end
    endcase

    // Walls and screen edges stop horizontal motion into them.
    if (nXs > 0 && (xPix >= X_MAX || (collision_i && hitEdgeCode_i[1])))
      nXs = 0;
    if (nXs < 0 && (xPix <= X_MIN || (collision_i && hitEdgeCode_i[3])))
      nXs = 0;

    sumX = xPos_q + nXs;
    if (sumX > X_MAXF)
      newX = X_MAXF;
    else if (sumX < X_MINF)
      newX = X_MINF;
    else
      newX = sumX;

    newY    = yPos_q + nYs;
    newYPix = newY >>> FRAC_BITS;
  end

  always_comb begin
    state_d      = state_q;
    xPos_d       = xPos_q;
    yPos_d       = yPos_q;
    xSpeed_d     = xSpeed_q;
    ySpeed_d     = ySpeed_q;
    facingLeft_d = facingLeft_q;
    fellOut_d    = 1'b0;

    if (respawn_i) begin
      state_d  = GROUND;
      xPos_d   = INIT_XF;
      yPos_d   = INIT_YF;
      xSpeed_d = 0;
      ySpeed_d = 0;
    end else if (startOfFrame_i) begin
      if (leftOnly)
        facingLeft_d = 1'b1;
      else if (rightOnly)
        facingLeft_d = 1'b0;

      if (newYPix >= Y_FLOOR) begin
        state_d   = GROUND;
        xPos_d    = INIT_XF;
        yPos_d    = INIT_YF;
        xSpeed_d  = 0;
        ySpeed_d  = 0;
        fellOut_d = 1'b1;
      end else begin
        state_d  = nextState;
        xPos_d   = newX;
        yPos_d   = newY;
        xSpeed_d = nXs;
        ySpeed_d = nYs;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= GROUND;
      xPos_q       <= INIT_XF;
      yPos_q       <= INIT_YF;
      xSpeed_q     <= '0;
      ySpeed_q     <= '0;
      facingLeft_q <= 1'b0;
      fellOut_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      xPos_q       <= xPos_d;
      yPos_q       <= yPos_d;
      xSpeed_q     <= xSpeed_d;
      ySpeed_q     <= ySpeed_d;
      facingLeft_q <= facingLeft_d;
      fellOut_q    <= fellOut_d;
    end
  end

  assign topLeftX_o    = xPix[COORD_W-1:0];
  assign topLeftY_o    = yPos_q[FRAC_BITS +: COORD_W];
  assign motionState_o = state_q;
  assign facingLeft_o  = facingLeft_q;
  assign fellOut_o     = fellOut_q;

endmodule

// File: tb/tb_actor_motion_fsm.sv
// Scoreboard bench for actor_motion_fsm: each frame pushes its expected
// sprite outputs, which are popped and compared after the clock edge.
module tb_actor_motion_fsm;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        leftPressed, rightPressed, upPressed, downPressed;
  logic        collision, onLedge, onRope;
  logic [3:0]  hitEdgeCode;
  logic        respawn;
  logic [10:0] topLeftX, topLeftY;
  logic [1:0]  motionState;
  logic        facingLeft, fellOut;

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    st;
    int    fl;
    int    fo;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  actor_motion_fsm dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame_i(startOfFrame),
    .leftPressed_i (leftPressed),
    .rightPressed_i(rightPressed),
    .upPressed_i   (upPressed),
    .downPressed_i (downPressed),
    .collision_i   (collision),
    .onLedge_i     (onLedge),
    .onRope_i      (onRope),
    .hitEdgeCode_i (hitEdgeCode),
    .respawn_i     (respawn),
    .topLeftX_o    (topLeftX),
    .topLeftY_o    (topLeftY),
    .motionState_o (motionState),
    .facingLeft_o  (facingLeft),
    .fellOut_o     (fellOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit sof, input string tag, input int ex,
                               input int ey, input int est, input int efl,
                               input int efo);
    expT e;
    expT got;
    e.tag = tag;
    e.x   = ex;
    e.y   = ey;
    e.st  = est;
    e.fl  = efl;
    e.fo  = efo;
    expQ.push_back(e);
    startOfFrame = sof;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    respawn      = 1'b0;
    got = expQ.pop_front();
    checkOutput({got.tag, ".x"}, $signed(topLeftX), got.x);
    checkOutput({got.tag, ".y"}, $signed(topLeftY), got.y);
    checkOutput({got.tag, ".state"}, {30'd0, motionState}, got.st);
    checkOutput({got.tag, ".facing"}, {31'd0, facingLeft}, got.fl);
    checkOutput({got.tag, ".fellOut"}, {31'd0, fellOut}, got.fo);
  endtask

  task automatic setInputs(input logic l, input logic r, input logic u,
                           input logic d, input logic c, input logic ledge,
                           input logic rope, input logic [3:0] edgeCode);
    leftPressed  = l;
    rightPressed = r;
    upPressed    = u;
    downPressed  = d;
    collision    = c;
    onLedge      = ledge;
    onRope       = rope;
    hitEdgeCode  = edgeCode;
  endtask

  initial begin
    int y;
    int ys;
    int x;
    bit fellSeen;

    resetN       = 1'b0;
    startOfFrame = 1'b0;
    respawn      = 1'b0;
    setInputs(0, 0, 0, 0, 0, 0, 0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, "reset", 280, 185, 0, 0, 0);
    resetN = 1'b1;

    // Inputs active but no frame pulse: nothing may move.
    setInputs(0, 1, 1, 0, 1, 1, 0, 4'b0001);
    repeat (99) @(posedge clk);
    #1;
    applyStimulus(0, "idle100", 280, 185, 0, 0, 0);

    setInputs(0, 1, 0, 0, 1, 1, 0, 4'b0001);
    applyStimulus(1, "walkR1", 283, 185, 0, 0, 0);
    applyStimulus(1, "walkR2", 286, 185, 0, 0, 0);
    applyStimulus(1, "walkR3", 289, 185, 0, 0, 0);
    setInputs(1, 1, 0, 0, 1, 1, 0, 4'b0001);
    applyStimulus(1, "bothLR1", 289, 185, 0, 0, 0);
    applyStimulus(1, "bothLR2", 289, 185, 0, 0, 0);
    setInputs(1, 0, 0, 0, 1, 1, 0, 4'b0001);
    applyStimulus(1, "walkL", 286, 185, 0, 1, 0);
    setInputs(0, 1, 0, 0, 1, 1, 0, 4'b0001);
    applyStimulus(1, "walkRback", 289, 185, 0, 0, 0);

    setInputs(0, 0, 1, 0, 1, 1, 0, 4'b0001);
    applyStimulus(1, "jump", 289, 180, 1, 0, 0);
    setInputs(0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus(1, "rise", 289, 175, 1, 0, 0);

    y        = 11250;
    ys       = -290;
    fellSeen = 1'b0;
    for (int i = 0; i < 300 && !fellSeen; i++) begin
      ys = ys + 10;
      if (ys > 230) ys = 230;
      y = y + ys;
      if ((y >>> 6) >= 479) begin
        applyStimulus(1, "fallOut", 280, 185, 0, 0, 1);
        fellSeen = 1'b1;
      end else begin
        applyStimulus(1, "fall", 289, y >>> 6, 1, 0, 0);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("fellOutPulse", {31'd0, fellOut}, 0);

    setInputs(0, 0, 1, 0, 0, 0, 1, 4'b0000);
    applyStimulus(1, "ropeGrab", 280, 183, 2, 0, 0);
    applyStimulus(1, "climbUp", 280, 181, 2, 0, 0);
    setInputs(0, 0, 0, 1, 0, 0, 1, 4'b0000);
    applyStimulus(1, "climbDn1", 280, 183, 2, 0, 0);
    applyStimulus(1, "climbDn2", 280, 185, 2, 0, 0);
    setInputs(0, 0, 0, 0, 0, 0, 1, 4'b0000);
    applyStimulus(1, "climbHold", 280, 185, 2, 0, 0);
    setInputs(1, 0, 0, 0, 0, 0, 1, 4'b0000);
    applyStimulus(1, "jumpOff", 276, 185, 1, 1, 0);
    setInputs(0, 1, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus(1, "airRight", 280, 185, 1, 0, 0);

    // Respawn wins over a simultaneous frame update.
    setInputs(0, 1, 0, 0, 1, 1, 0, 4'b0001);
    respawn = 1'b1;
    applyStimulus(1, "respawnSof", 280, 185, 0, 0, 0);

    x = 17920;
    for (int k = 0; k < 95; k++) begin
      x = x + 200;
      if (x > 36480) x = 36480;
      applyStimulus(1, "walkToMax", x >>> 6, 185, 0, 0, 0);
    end

    setInputs(0, 0, 1, 0, 1, 1, 0, 4'b0001);
    applyStimulus(1, "jumpAtMax", 570, 180, 1, 0, 0);
    setInputs(0, 0, 0, 0, 1, 0, 0, 4'b0100);
    applyStimulus(1, "headBump", 570, 180, 1, 0, 0);
    setInputs(0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus(1, "afterBump", 570, 180, 1, 0, 0);

    respawn = 1'b1;
    applyStimulus(0, "respawnAir", 280, 185, 0, 0, 0);
    setInputs(0, 0, 0, 0, 1, 1, 0, 4'b0001);
    applyStimulus(1, "postRespawn", 280, 185, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/actor_motion_fsm.md
Name: actor_motion_fsm

Overview:
- Parametrised per-actor motion controller for sprites on the game screen: player, enemies, and climbing objects.
- Replaces the fixed-constant movement logic with an explicit GROUND/AIR/CLIMB state machine, and adds parametrised physics, screen clamping, head-bump, fall-out detection and respawn.
- Sits between the keyboard/AI direction inputs and collision detector on one side, and the sprite drawer on the other.
- Positions are kept in signed fixed point and updated once per frame.

Parameters:
- COORD_W, 11: width of signed pixel-coordinate outputs.
- FRAC_BITS, 6: fractional bits of internal position; scale = 2^FRAC_BITS.
- INIT_X, 280: reset/respawn X, in pixels.
- INIT_Y, 185: reset/respawn Y, in pixels.
- X_MIN, -9: leftmost allowed topLeftX.
- X_MAX, 570: rightmost allowed topLeftX.
- Y_FLOOR, 479: topLeftY at or beyond this value means the actor fell out.
- WALK_SPEED, 200: X speed magnitude, in fixed-point units per frame.
- CLIMB_SPEED, 100: rope climb speed magnitude.
- JUMP_SPEED, 300: initial upward speed of a jump.
- GRAVITY, 10: Y speed increment per frame in AIR.
- MAX_FALL, 230: maximum downward Y speed.

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous, active-low reset.
- startOfFrame, in, 1: one-cycle pulse per frame; all state and position updates occur only on this cycle.
- leftPressed, rightPressed, upPressed, downPressed, in, 1 each: direction requests.
- collision, in, 1: sprite overlaps some object this frame.
- onLedge, in, 1: the overlapped object is a ledge.
- onRope, in, 1: sprite overlaps a rope.
- hitEdgeCode, in, 4: overlap edge. [3]=left, [2]=top, [1]=right, [0]=bottom.
- respawn, in, 1: synchronous request to return to INIT position.
- topLeftX, out, COORD_W: signed pixel X.
- topLeftY, out, COORD_W: signed pixel Y.
- motionState, out, 2: 0=GROUND, 1=AIR, 2=CLIMB. Encoding 3 is unused.
- facingLeft, out, 1: last horizontal direction.
- fellOut, out, 1: one-cycle pulse on respawn caused by falling out.

Behaviour:
- Reset (async):
  - X position = INIT_X<<FRAC_BITS; Y position = INIT_Y<<FRAC_BITS.
  - Xspeed = Yspeed = 0.
  - motionState = GROUND; facingLeft = 0; fellOut = 0.
- Internal arithmetic:
  - Positions and speeds are 32-bit signed.
  - Pixel outputs = position >>> FRAC_BITS (arithmetic shift, floor), truncated to COORD_W.
- Update rule: on a startOfFrame cycle, next state, new speeds (nXs, nYs) and new position = old position + new speed are all computed from inputs sampled that cycle. Registers hold on all other cycles.
- X speed:
  - Exactly one of left/right pressed: nXs = ±WALK_SPEED.
  - Both or neither pressed: nXs = 0.
  - Force nXs = 0 if moving right and (topLeftX >= X_MAX or (collision & hitEdgeCode[1])).
  - Force nXs = 0 if moving left and (topLeftX <= X_MIN or (collision & hitEdgeCode[3])).
  - In CLIMB, nXs = 0 unless the state leaves CLIMB on that frame.
  - New X is clamped to [X_MIN, X_MAX] in pixels: exact X_MAX<<FRAC_BITS or X_MIN<<FRAC_BITS.
- facingLeft: set by left-only, cleared by right-only, held otherwise.
- footing = onLedge & collision.
- GROUND:
  - up & onRope -> CLIMB, nYs = -CLIMB_SPEED.
  - else up -> AIR, nYs = -JUMP_SPEED.
  - else !footing & !onRope -> AIR, nYs = 0 (walked off an edge).
  - else stay, nYs = 0.
- CLIMB:
  - !onRope -> AIR, nYs = 0.
  - left xor right pressed -> AIR (jump-off), nXs = ±WALK_SPEED, nYs = 0.
  - Otherwise nYs = -CLIMB_SPEED if up only, +CLIMB_SPEED if down only, else 0.
- AIR:
  - onRope -> CLIMB, nYs = 0.
  - else footing & Yspeed >= 0 -> GROUND, nYs = 0.
  - else collision & hitEdgeCode[2] & Yspeed < 0 -> nYs = 0 (head-bump, stay AIR).
  - else nYs = min(Yspeed + GRAVITY, MAX_FALL).
- Fall-out: if the new topLeftY >= Y_FLOOR:
  - Position is reloaded to INIT; speeds = 0; state = GROUND.
  - fellOut pulses high for that single cycle.
- Respawn input:
  - respawn on any cycle reloads INIT position, zeroes speeds and sets GROUND on the next edge.
  - fellOut does not pulse.
  - respawn has priority over all frame updates in the same cycle.
- Simultaneous events: respawn > fall-out > state transitions. Transition priority within each state follows the listed order.

Test Plan:
- Reset -> topLeftX=280, topLeftY=185, motionState=0, facingLeft=0, fellOut=0. Hold with no startOfFrame for 100 cycles -> outputs unchanged.
- footing=1, rightPressed, 3 frames -> X fixed = 17920+600 = 18520, topLeftX=289, facingLeft=0. Add leftPressed as well -> X frozen.
- footing=1, upPressed for 1 frame -> motionState=1, Y=11840-300=11540, topLeftY=180. Next frame, inputs idle -> Yspeed=-290, Y=11250, topLeftY=175.
- AIR with no footing for 60 frames -> Yspeed saturates at 230. On reaching topLeftY>=479 -> fellOut high for exactly 1 cycle, position back to (280,185), motionState=0.
- GROUND with onRope=1, upPressed -> CLIMB, Y decreases by 100 per frame. Release up and press down -> +100 per frame. Press leftPressed -> AIR, Xspeed=-200, facingLeft=1.
- Walk right from topLeftX=568 -> clamps at 570 and Xspeed=0. Then AIR, Yspeed<0, with collision and hitEdgeCode=4'b0100 -> Yspeed=0, stays AIR. Assert respawn mid-jump -> INIT position next cycle, no fellOut.
